// File: rtl/tree_io_pkg.sv
// Shared definitions for the feature loader and the external tree classifier.
package tree_io_pkg;

  localparam int NUM_FEAT_DEF = 20;
  localparam int FEAT_W       = 8;
  localparam int CLASS_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } ld_state_t;

  // Slots 4 and 5 carry no information for the classifier; they are stored as zero.
  function automatic logic is_unused_slot(input int unsigned slot);
    return (slot == 4) || (slot == 5);
  endfunction

endpackage

// File: rtl/feature_frame_loader.sv
// Collects one frame of feature bytes, holds it for the external classifier,
// captures the class after a settle time and hands it downstream.
module feature_frame_loader
  import tree_io_pkg::*;
#(
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int EVAL_CYC = 2,
  parameter int CLASS_W  = CLASS_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_valid,
  input  logic                       s_first,
  output logic                       s_ready,
  output logic [FEAT_W*NUM_FEAT-1:0] feat_vec,
  input  logic [CLASS_W-1:0]         cls_in,
  output logic [CLASS_W-1:0]         m_class,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [15:0]                frame_cnt
);

  localparam int IDX_W = $clog2(NUM_FEAT);

  ld_state_t        state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       eval_cnt;

  logic             xfer;
  logic             wr_en;
  logic [IDX_W-1:0] wr_slot;
  logic             last_wr;

  assign xfer = s_valid && s_ready;

  // s_first always restarts at slot 0; a byte without s_first before any start is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = idx;
    if (xfer) begin
      if (s_first) begin
        wr_en   = 1'b1;
        wr_slot = '0;
      end else if (idx != '0) begin
        wr_en = 1'b1;
      end
    end
  end

  assign last_wr = wr_en && (wr_slot == IDX_W'(NUM_FEAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      eval_cnt  <= '0;
      feat_vec  <= '0;
      m_class   <= '0;
      m_valid   <= 1'b0;
      frame_cnt <= '0;
      s_ready   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          if (wr_en) begin
            feat_vec[FEAT_W*wr_slot +: FEAT_W] <=
              is_unused_slot(32'(wr_slot)) ? '0 : s_data;
            if (last_wr) begin
              idx      <= '0;
              eval_cnt <= '0;
              s_ready  <= 1'b0;
              state    <= ST_EVAL;
            end else begin
              idx <= wr_slot + 1'b1;
            end
          end
        end
        ST_EVAL: begin
          if (eval_cnt == 4'(EVAL_CYC - 1)) begin
            m_class  <= cls_in;
            m_valid  <= 1'b1;
            eval_cnt <= '0;
            state    <= ST_OUT;
          end else begin
            eval_cnt <= eval_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            s_ready   <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        default: begin
          state   <= ST_LOAD;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_frame_loader.sv
// Randomized and directed bench for feature_frame_loader against a frame-level reference model.
module tb_feature_frame_loader;
  import tree_io_pkg::*;

  localparam int NF = 20;
  localparam int EC = 2;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_first = 1'b0;
  logic              s_ready;
  logic [8*NF-1:0]   feat_vec;
  logic [CW-1:0]     cls_in;
  logic [CW-1:0]     m_class;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [15:0]       frame_cnt;

  logic              cls_ovr_en = 1'b0;
  logic [CW-1:0]     cls_ovr = '0;

  always #5 clk = ~clk;

  feature_frame_loader #(.NUM_FEAT(NF), .EVAL_CYC(EC), .CLASS_W(CW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_first(s_first),
    .s_ready(s_ready), .feat_vec(feat_vec), .cls_in(cls_in), .m_class(m_class),
    .m_valid(m_valid), .m_ready(m_ready), .frame_cnt(frame_cnt)
  );

  // Stand-in classifier: any deterministic function of the feature vector will do.
  function automatic logic [CW-1:0] toy_cls(input logic [8*NF-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < NF; i++) s += int'(v[8*i +: 8]) ^ i;
    return CW'(s);
  endfunction

  assign cls_in = cls_ovr_en ? cls_ovr : toy_cls(feat_vec);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the outside world should see.
  bit              armed = 1'b0;
  bit              just_rst = 1'b0;
  bit              e_ready = 1'b0;
  bit              e_mvalid = 1'b0;
  logic [8*NF-1:0] e_feat = '0;
  logic [CW-1:0]   e_cls = '0;
  logic [15:0]     e_cnt = '0;
  int              pos = 0;
  int              eval_left = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit            acc;
    bit            hs;
    logic [7:0]    d;
    bit            f;
    logic [CW-1:0] cls_now;
    int            slot;
    if (armed) begin
      check("s_ready", s_ready, e_ready);
      check("m_valid", m_valid, e_mvalid);
      check("m_class", m_class, e_cls);
      check("frame_cnt", frame_cnt, e_cnt);
      check("feat_vec", feat_vec, e_feat);
    end
    acc     = e_ready && s_valid;
    hs      = e_mvalid && m_ready;
    d       = s_data;
    f       = s_first;
    cls_now = cls_ovr_en ? cls_ovr : toy_cls(e_feat);
    @(posedge clk);
    #1;
    if (rst) begin
      armed = 1'b1; just_rst = 1'b1; e_ready = 1'b0; e_mvalid = 1'b0;
      e_feat = '0; e_cls = '0; e_cnt = '0; pos = 0; eval_left = 0;
    end else if (armed) begin
      if (just_rst) begin
        just_rst = 1'b0;
        e_ready  = 1'b1;
      end else if (acc) begin
        slot = f ? 0 : ((pos == 0) ? -1 : pos);
        if (slot >= 0) begin
          e_feat[8*slot +: 8] = (slot == 4 || slot == 5) ? 8'h00 : d;
          pos = slot + 1;
          if (slot == NF - 1) begin
            pos = 0; e_ready = 1'b0; eval_left = EC;
          end
        end
      end else if (eval_left > 0) begin
        eval_left--;
        if (eval_left == 0) begin
          e_cls = cls_now; e_mvalid = 1'b1;
        end
      end else if (hs) begin
        e_mvalid = 1'b0; e_cnt = e_cnt + 16'd1; e_ready = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input bit f);
    s_valid = 1'b1; s_data = d; s_first = f;
    tick();
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < NF; i++) send(base + 8'(i), i == 0);
  endtask

  task automatic wait_mvalid(input int maxc);
    int n;
    n = 0;
    while (!m_valid && n < maxc) begin
      tick();
      n++;
    end
    if (!m_valid) check("m_valid_timeout", 0, 1);
  endtask

  int lat;

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_s_ready", s_ready, 0);
    check("rst_feat_vec", feat_vec, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    tick();

    // First frame, result held back for five cycles
    cls_ovr_en = 1'b1; cls_ovr = 2'b11; m_ready = 1'b0;
    for (int i = 0; i < NF - 1; i++) send(8'h10 + 8'(i), i == 0);
    lat = 0;
    send(8'h23, 1'b0);
    lat = 1;
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, EC + 1);
    check("slot0", feat_vec[7:0], 8'h10);
    check("slot3", feat_vec[31:24], 8'h13);
    check("slot4", feat_vec[39:32], 8'h00);
    check("slot5", feat_vec[47:40], 8'h00);
    check("slot19", feat_vec[159:152], 8'h23);
    idle(5);
    check("held_m_class", m_class, 2'b11);
    check("held_m_valid", m_valid, 1);
    check("held_s_ready", s_ready, 0);
    check("held_frame_cnt", frame_cnt, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("cnt_after_hs", frame_cnt, 1);
    cls_ovr_en = 1'b0;

    // Orphan bytes without a start marker are dropped
    for (int i = 0; i < NF + 3; i++) send(8'($urandom), 1'b0);
    idle(4);
    check("orphan_no_result", m_valid, 0);

    // Resync: partial frame abandoned by a new start byte
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), i == 0);
    send(8'hAA, 1'b1);
    for (int i = 1; i < NF; i++) send(8'h60 + 8'(i), 1'b0);
    wait_mvalid(20);
    check("resync_slot0", feat_vec[7:0], 8'hAA);
    idle(10);
    check("resync_one_result", frame_cnt, 2);

    // Reset mid-frame and again with a pending result
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'h80 + 8'(i), i == 0);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h8B;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check("rst1_feat_vec", feat_vec, 0);
    check("rst1_frame_cnt", frame_cnt, 0);
    idle(1);
    send_frame(8'h05);
    wait_mvalid(20);
    m_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; m_ready = 1'b0;
    check("rst2_m_valid", m_valid, 0);
    check("rst2_m_class", m_class, 0);
    check("rst2_frame_cnt", frame_cnt, 0);
    idle(2);

    // Counter wrap
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    e_cnt = 16'hFFFF;
    m_ready = 1'b1;
    send_frame(8'hC0);
    wait_mvalid(20);
    tick();
    check("cnt_wrap", frame_cnt, 16'h0000);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      s_first = (pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; s_valid = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_frame_loader.md
FEATURE_FRAME_LOADER -- requirements
Module: feature_frame_loader

Interface
REQ-001 SHALL have parameter NUM_FEAT, default 20, number of 8-bit feature slots per frame (X0..X19).
REQ-002 SHALL have parameter EVAL_CYC, default 2, cycles the classifier output settles before capture (1..15).
REQ-003 SHALL have parameter CLASS_W, default 2, class-code width.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_data  input  8  feature byte, slot order 0..NUM_FEAT-1.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_first  input  1  byte is slot 0 of a frame.
REQ-009 SHALL have port s_ready  output  1  loader accepts a byte.
REQ-010 SHALL have port feat_vec  output  8*NUM_FEAT  registered features; slot i at bits [8i+7:8i].
REQ-011 SHALL have port cls_in  input  CLASS_W  combinational class from the tree classifier driven by feat_vec.
REQ-012 SHALL have port m_class  output  CLASS_W  captured class.
REQ-013 SHALL have port m_valid  output  1  m_class valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts result.
REQ-015 SHALL have port frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-016 SHALL implement FSM LOAD -> EVAL -> OUT -> LOAD.
REQ-017 LOAD: s_ready=1; byte transfers when s_valid&&s_ready; writes slot idx, idx increments.
REQ-018 Slots 4 and 5 SHALL be stored as 0x00 regardless of s_data (unused features); they still consume a byte.
REQ-019 A transfer with s_first=1 SHALL write slot 0 and set idx=1, discarding any partial frame (resync).
REQ-020 Transfers with s_first=0 while idx=0 SHALL be dropped (no write, idx stays 0).
REQ-021 Transfer writing slot NUM_FEAT-1 SHALL move to EVAL next cycle; idx resets to 0.
REQ-022 EVAL: s_ready=0; counter counts EVAL_CYC cycles; feat_vec stable; on last EVAL cycle m_class<=cls_in, go OUT.
REQ-023 OUT: m_valid=1, m_class stable until m_valid&&m_ready; then frame_cnt+1 and return to LOAD same edge.
REQ-024 s_ready SHALL be 0 in EVAL and OUT (no frame overlap); byte-to-result latency = EVAL_CYC+1 cycles after last-byte edge.
REQ-025 feat_vec SHALL hold last completed frame through OUT and update only on LOAD writes.
REQ-026 m_valid SHALL not depend combinationally on m_ready; s_ready SHALL not depend combinationally on s_valid.

Reset
REQ-027 On rst: state LOAD, idx 0, EVAL counter 0, feat_vec 0, m_class 0, m_valid 0, frame_cnt 0; s_ready 0 during reset cycle, 1 the cycle after.
REQ-028 rst in any state, incl. mid-frame or OUT with pending result, SHALL discard all in-flight data with no output transfer.

Structure
REQ-029 NUM_FEAT default, FEAT_W=8, CLASS_W and state enum SHALL live in shared package tree_io_pkg.
REQ-030 Classifier SHALL be external (instantiated by wrapper); loader contains no tree logic; no sub-module required.

Verification
REQ-031 Reset then 20 bytes 0x10..0x23, s_first on first -> feat_vec slot0=0x10, slot19=0x23, slots4/5=0x00; m_valid rises EVAL_CYC+1 cycles after last byte.
REQ-032 cls_in=2'b11 during EVAL, m_ready held 0 for 5 cycles -> m_class=3, m_valid stays 1, s_ready=0, frame_cnt unchanged; m_ready=1 -> frame_cnt=1.
REQ-033 10 bytes, then s_first with 0xAA then 19 more -> frame slot0=0xAA, one result only.
REQ-034 Bytes with s_first=0 after reset -> ignored, idx 0, no m_valid.
REQ-035 rst asserted at byte 12 and again in OUT -> all outputs zero next cycle, no m_valid handshake.
REQ-036 Force frame_cnt via 65536 frames (or backdoor to 0xFFFF) -> next completed frame reads 0x0000.
